midori64_key_sched_ctrl: RTL and testbench

//  Sequencer for the Midori64 round-key datapath of the TI cipher core. It walks the 15 keyed rounds.
//  Per round it drives the k0/k1 select and the 16-bit round constant ALPHA[r] into round_key.
//  It frames each round for a multi-cycle shared (TI) round pipeline.
//  It brackets the rounds with input/output whitening phases (WK = k0^k1) and returns a done pulse.

---
 rtl/midori64_key_sched_ctrl.sv | 132 +++++++++++++
 tb/tb_midori64_key_sched_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/midori64_key_sched_ctrl.sv
// Midori64 round-key sequencer: walks the 15 keyed rounds of a multi-cycle TI round pipeline,
// drives k0/k1 select and ALPHA[r], and brackets the rounds with WK whitening phases.
module midori64_key_sched_ctrl #(
    parameter int NUM_ROUNDS       = 15,
    parameter int CYCLES_PER_ROUND = 3,
    parameter int ROUND_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               load_state,
    output logic               wk_en,
    output logic               key_sel,
    output logic [15:0]        constant,
    output logic [ROUND_W-1:0] round_idx,
    output logic [3:0]         round_cnt,
    output logic               rk_strobe,
    output logic               last_round,
    output logic               done,
    output logic [2:0]         state_dbg
);

    // Handshake: start is a level request sampled only in IDLE; while busy is high it is
    // ignored (no queueing), and held high it relaunches directly from the IDLE cycle.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WK_IN  = 3'd1,
        S_ROUND  = 3'd2,
        S_WK_OUT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]         CNT_LAST = 4'(CYCLES_PER_ROUND - 1);
    localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] RND_ONE  = ROUND_W'(1);

    // Midori64 round constants, cell 0 in bit 15; the spare 16th entry is never addressed.
    localparam logic [15:0] ALPHA [16] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213,
        16'h104F, 16'hD170, 16'h0266, 16'h0BCC,
        16'h9481, 16'h40B8, 16'h7197, 16'h228E,
        16'h5130, 16'hF8CA, 16'hDF90, 16'h0000
    };

    state_t             state;
    state_t             state_next;
    logic [ROUND_W-1:0] round_r;
    logic [ROUND_W-1:0] round_next;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_next;
    logic               in_round;
    logic               round_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            round_r <= '0;
            cnt_r   <= '0;
        end else begin
            state   <= state_next;
            round_r <= round_next;
            cnt_r   <= cnt_next;
        end
    end

    assign in_round  = (state == S_ROUND);
    assign round_end = in_round && (cnt_r == CNT_LAST);

    always_comb begin
        state_next = state;
        round_next = '0;
        cnt_next   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WK_IN;
                end
            end
            S_WK_IN: begin
                state_next = S_ROUND;
            end
            S_ROUND: begin
                if (cnt_r == CNT_LAST) begin
                    if (round_r == RND_LAST) begin
                        state_next = S_WK_OUT;
                    end else begin
                        round_next = round_r + RND_ONE;
                    end
                end else begin
                    round_next = round_r;
                    cnt_next   = cnt_r + 4'd1;
                end
            end
            S_WK_OUT: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only, so start never reaches an output combinationally.
    always_comb begin
        busy       = (state != S_IDLE);
        load_state = (state == S_WK_IN);
        wk_en      = (state == S_WK_IN) || (state == S_WK_OUT);
        done       = (state == S_DONE);
        key_sel    = 1'b0;
        constant   = 16'h0000;
        round_idx  = '0;
        round_cnt  = 4'd0;
        rk_strobe  = 1'b0;
        last_round = 1'b0;
        if (in_round) begin
            key_sel    = round_r[0];
            constant   = ALPHA[round_r];
            round_idx  = round_r;
            round_cnt  = cnt_r;
            rk_strobe  = round_end;
            last_round = (round_r == RND_LAST);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_midori64_key_sched_ctrl.sv
// Directed bench for midori64_key_sched_ctrl: cycle-by-cycle comparison against a timing
// model built from the golden ALPHA table, for C=3 (main instance) and C=1 (back-to-back).
module tb_midori64_key_sched_ctrl;

    localparam int N = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        busy_a, load_a, wk_a, ksel_a, rks_a, last_a, done_a;
    logic [15:0] cst_a;
    logic [3:0]  ridx_a, rcnt_a;
    logic [2:0]  st_a;
    logic        busy_b, load_b, wk_b, ksel_b, rks_b, last_b, done_b;
    logic [15:0] cst_b;
    logic [3:0]  ridx_b, rcnt_b;
    logic [2:0]  st_b;

    logic [30:0] obs_a, obs_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] golden [15];

    // clock / reset block
    always #5 clk = ~clk;

    midori64_key_sched_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .busy(busy_a), .load_state(load_a), .wk_en(wk_a), .key_sel(ksel_a),
        .constant(cst_a), .round_idx(ridx_a), .round_cnt(rcnt_a),
        .rk_strobe(rks_a), .last_round(last_a), .done(done_a), .state_dbg(st_a)
    );

    midori64_key_sched_ctrl #(.CYCLES_PER_ROUND(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .busy(busy_b), .load_state(load_b), .wk_en(wk_b), .key_sel(ksel_b),
        .constant(cst_b), .round_idx(ridx_b), .round_cnt(rcnt_b),
        .rk_strobe(rks_b), .last_round(last_b), .done(done_b), .state_dbg(st_b)
    );

    assign obs_a = {busy_a, load_a, wk_a, ksel_a, cst_a, ridx_a, rcnt_a, rks_a, last_a, done_a};
    assign obs_b = {busy_b, load_b, wk_b, ksel_b, cst_b, ridx_b, rcnt_b, rks_b, last_b, done_b};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output vector k cycles after the start-sampling edge (k=1 is WK_IN).
    function automatic logic [30:0] exp_vec(input int k, input int c);
        logic [15:0] cst;
        logic [3:0]  ri;
        logic [3:0]  rc;
        int r;
        int s;
        if (k == 1) return {3'b111, 28'd0};
        if (k >= 2 && k <= 1 + N * c) begin
            r   = (k - 2) / c;
            s   = (k - 2) % c;
            cst = golden[r];
            ri  = 4'(r);
            rc  = 4'(s);
            return {1'b1, 1'b0, 1'b0, ri[0], cst, ri, rc, (s == c - 1), (r == N - 1), 1'b0};
        end
        if (k == 2 + N * c) return {3'b101, 28'd0};
        if (k == 3 + N * c) return {1'b1, 29'd0, 1'b1};
        return 31'd0;
    endfunction

    // driver: one C=3 run; mode 0 plain, mode 1 stray start at r=5, mode 2 reset at r=7/cnt=1
    task automatic run_a(input int mode);
        int dones;
        int strobes;
        int first_done;
        logic [30:0] e;
        dones = 0;
        strobes = 0;
        first_done = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (mode == 2 && k == 25) begin
                check_val("abort_idle", {1'b0, obs_a}, 32'd0);
                check_val("abort_state", {29'd0, st_a}, 32'd0);
                rst = 1'b0;
                break;
            end
            e = exp_vec(k, 3);
            check_val($sformatf("run%0d_k%0d", mode, k), {1'b0, obs_a}, {1'b0, e});
            if (rks_a) strobes++;
            if (done_a) begin
                dones++;
                if (first_done == 0) first_done = k;
            end
            if (mode == 1 && k == 17) start_a = 1'b1;
            if (mode == 2 && k == 24) rst = 1'b1;
        end
        if (mode != 2) begin
            check_val($sformatf("run%0d_strobes", mode), 32'(strobes), 32'd15);
            check_val($sformatf("run%0d_dones", mode), 32'(dones), 32'd1);
            check_val($sformatf("run%0d_done_lat", mode), 32'(first_done), 32'd48);
        end else begin
            check_val("abort_no_done", 32'(dones), 32'd0);
        end
    endtask

    initial begin
        int dones;
        int last_done;
        int p;
        golden = '{16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266,
                   16'h0BCC, 16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA,
                   16'hDF90};

        // T1: reset with start held high
        start_a = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_outs_a", {1'b0, obs_a}, 32'd0);
            check_val("rst_outs_b", {1'b0, obs_b}, 32'd0);
            check_val("rst_state", {29'd0, st_a}, 32'd0);
        end
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("idle_a", {1'b0, obs_a}, 32'd0);
        end

        // T2/T3: nominal run, T4: start while busy
        run_a(0);
        run_a(1);
        // T5: reset mid-run, then a fresh full run
        run_a(2);
        @(negedge clk);
        check_val("post_abort_idle", {1'b0, obs_a}, 32'd0);
        run_a(0);

        // T6: C=1 with start held high, three back-to-back runs
        dones = 0;
        last_done = 0;
        @(negedge clk);
        start_b = 1'b1;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk);
            p = ((k - 1) % 19) + 1;
            if (k == 58) p = 19;
            check_val($sformatf("c1_k%0d", k), {1'b0, obs_b}, {1'b0, exp_vec(p, 1)});
            if (done_b) begin
                dones++;
                if (last_done != 0) check_val("c1_done_gap", 32'(k - last_done), 32'd19);
                last_done = k;
            end
            if (k == 57) start_b = 1'b0;
        end
        check_val("c1_dones", 32'(dones), 32'd3);
        check_val("c1_first_done", 32'(last_done), 32'd56);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
